seg_decode: RTL and testbench

Receive-side monitor for the six-digit seven-segment display bus (`sel` digit enables and `seg` active-low segment patterns). It samples the bus and waits for each pattern to hold steady. It then maps the pattern back to a hex nibble and decimal-point bit and keeps the result in a per-digit register file. It works with static (all digits enabled) and scanned (one-hot) drive. Typical uses are loopback self-check on the board and display-content readback for the host debug path.

---
 rtl/seg_decode_if.sv | 13 +
 rtl/seg_decode.sv | 179 +++++++++++++++++
 tb/tb_seg_decode.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/seg_decode_if.sv
// seg_decode_if -- six-digit seven-segment display bus.
//
// The display driver is the master. It drives the digit enables and the segment
// pattern. The decode monitor is the slave and only samples them.
//   sel : digit enables, active-high, bit i drives digit i
//   seg : segment pattern, active-low, bit7 = dp, bits6..0 = g..a
interface seg_decode_if;
    logic [5:0] sel;
    logic [7:0] seg;

    modport master (output sel, output seg);
    modport slave  (input  sel, input  seg);
endinterface

// File: rtl/seg_decode.sv
// seg_decode -- receive-side monitor for the six-digit seven-segment display bus.
//
// The monitor samples the bus and waits for each sel/seg pair to hold for
// STABLE_CYC clocks. It then decodes the active-low pattern back to a hex nibble
// and a decimal-point bit, and stores the result for every enabled digit. It
// handles both static drive (all digits enabled) and scanned drive (one-hot).
//
// Configuration macro: SEG_DECODE_ERR_EN
//   defined   : an unrecognised pattern is still captured. The target nibbles
//               become Fh and the digit_err bits are set.
//   undefined : an unrecognised pattern is discarded and digit_err stays 0.
//
// Ports:
//   sys_clk     system clock, rising edge
//   sys_rst_n   asynchronous active-low reset
//   bus         seg_decode_if.slave (sel[5:0], seg[7:0])
//   digits      captured nibbles, digit i in [4i+3:4i]
//   dp          captured decimal points, 1 = lit
//   digit_err   last capture for the digit was an unrecognised pattern
//   upd         one-clock pulse on every capture
//   frame_done  one-clock pulse when all six digits have been captured
//   data_valid  set by the first frame_done, held until reset
module seg_decode #(
    parameter int unsigned STABLE_CYC = 16
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    seg_decode_if.slave   bus,
    output logic [23:0]   digits,
    output logic [5:0]    dp,
    output logic [5:0]    digit_err,
    output logic          upd,
    output logic          frame_done,
    output logic          data_valid
);

    localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYC);
    localparam logic [7:0] STABLE_M1  = 8'(STABLE_CYC - 1);

    // Returns {recognised, nibble} for a 7-bit active-low g..a pattern.
    function automatic logic [4:0] seg_to_nibble(input logic [6:0] pat);
        logic [4:0] res;
        case (pat)
            7'h40:   res = {1'b1, 4'h0};
            7'h79:   res = {1'b1, 4'h1};
            7'h24:   res = {1'b1, 4'h2};
            7'h30:   res = {1'b1, 4'h3};
            7'h19:   res = {1'b1, 4'h4};
            7'h12:   res = {1'b1, 4'h5};
            7'h02:   res = {1'b1, 4'h6};
            7'h78:   res = {1'b1, 4'h7};
            7'h00:   res = {1'b1, 4'h8};
            7'h10:   res = {1'b1, 4'h9};
            7'h08:   res = {1'b1, 4'hA};
            7'h03:   res = {1'b1, 4'hB};
            7'h46:   res = {1'b1, 4'hC};
            7'h21:   res = {1'b1, 4'hD};
            7'h06:   res = {1'b1, 4'hE};
            7'h0E:   res = {1'b1, 4'hF};
            default: res = {1'b0, 4'h0};
        endcase
        return res;
    endfunction

    logic [5:0]  s_sel_r;
    logic [7:0]  s_seg_r;
    logic [7:0]  cnt_r;
    logic [5:0]  cap_mask_r;
    logic [23:0] digits_r;
    logic [5:0]  dp_r;
    logic [5:0]  digit_err_r;
    logic        upd_r;
    logic        frame_done_r;
    logic        data_valid_r;

    logic        in_same_s;
    logic [7:0]  cnt_nxt_s;
    logic        capture_s;
    logic [4:0]  dec_s;
    logic        accept_s;
    logic [3:0]  wr_nib_s;
    logic        wr_err_s;
    logic        write_s;
    logic [5:0]  mask_or_s;
    logic        frame_s;
    logic [23:0] digits_nxt_s;
    logic [5:0]  dp_nxt_s;
    logic [5:0]  err_nxt_s;

    // Stability counting and capture detection against the sampled bus.
    always_comb begin
        in_same_s = ({bus.sel, bus.seg} == {s_sel_r, s_seg_r});
        if (!in_same_s) begin
            cnt_nxt_s = 8'd0;
        end else if (cnt_r < STABLE_MAX) begin
            cnt_nxt_s = cnt_r + 8'd1;
        end else begin
            cnt_nxt_s = cnt_r;
        end
        // The counter saturates at STABLE_MAX, so STABLE_M1 is reached
        // only once per stable period and capture cannot repeat.
        capture_s = in_same_s && (cnt_r == STABLE_M1);
    end

    // Pattern decode, accept policy and next values of the register file.
    always_comb begin
        dec_s = seg_to_nibble(s_seg_r[6:0]);
`ifdef SEG_DECODE_ERR_EN
        accept_s = 1'b1;
        wr_nib_s = dec_s[4] ? dec_s[3:0] : 4'hF;
        wr_err_s = ~dec_s[4];
`else
        accept_s = dec_s[4];
        wr_nib_s = dec_s[3:0];
        wr_err_s = 1'b0;
`endif
        write_s   = capture_s && (s_sel_r != 6'd0) && accept_s;
        mask_or_s = cap_mask_r | s_sel_r;
        frame_s   = write_s && (mask_or_s == 6'h3F);

        digits_nxt_s = digits_r;
        dp_nxt_s     = dp_r;
        err_nxt_s    = digit_err_r;
        for (int i = 0; i < 6; i++) begin
            if (s_sel_r[i]) begin
                digits_nxt_s[4*i +: 4] = wr_nib_s;
                dp_nxt_s[i]            = ~s_seg_r[7];
                err_nxt_s[i]           = wr_err_s;
            end else begin
                digits_nxt_s[4*i +: 4] = digits_r[4*i +: 4];
                dp_nxt_s[i]            = dp_r[i];
                err_nxt_s[i]           = digit_err_r[i];
            end
        end
    end

    // Input sampling, counter, register file, frame tracking and output pulses.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            s_sel_r      <= 6'h00;
            s_seg_r      <= 8'hFF;
            cnt_r        <= 8'd0;
            cap_mask_r   <= 6'h00;
            digits_r     <= 24'h000000;
            dp_r         <= 6'h00;
            digit_err_r  <= 6'h00;
            upd_r        <= 1'b0;
            frame_done_r <= 1'b0;
            data_valid_r <= 1'b0;
        end else begin
            s_sel_r      <= bus.sel;
            s_seg_r      <= bus.seg;
            cnt_r        <= cnt_nxt_s;
            upd_r        <= write_s;
            frame_done_r <= frame_s;
            if (write_s) begin
                digits_r    <= digits_nxt_s;
                dp_r        <= dp_nxt_s;
                digit_err_r <= err_nxt_s;
                // A completed frame clears the whole mask, with no carry-over.
                cap_mask_r  <= frame_s ? 6'h00 : mask_or_s;
            end else begin
                digits_r    <= digits_r;
                dp_r        <= dp_r;
                digit_err_r <= digit_err_r;
                cap_mask_r  <= cap_mask_r;
            end
            data_valid_r <= data_valid_r | frame_s;
        end
    end

    assign digits     = digits_r;
    assign dp         = dp_r;
    assign digit_err  = digit_err_r;
    assign upd        = upd_r;
    assign frame_done = frame_done_r;
    assign data_valid = data_valid_r;

endmodule

// File: tb/tb_seg_decode.sv
// tb_seg_decode -- directed self-checking bench for seg_decode (STABLE_CYC = 16).
module tb_seg_decode;

    logic        sys_clk;
    logic        sys_rst_n;
    logic [23:0] digits;
    logic [5:0]  dp;
    logic [5:0]  digit_err;
    logic        upd;
    logic        frame_done;
    logic        data_valid;

    int checks;
    int failures;
    int upd_cnt;
    int frame_cnt;

    seg_decode_if bus ();

    seg_decode #(.STABLE_CYC(16)) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .bus        (bus),
        .digits     (digits),
        .dp         (dp),
        .digit_err  (digit_err),
        .upd        (upd),
        .frame_done (frame_done),
        .data_valid (data_valid)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Pulse counters, sampled on the falling edge.
    initial begin
        upd_cnt   = 0;
        frame_cnt = 0;
    end
    always @(negedge sys_clk) begin
        if (upd) upd_cnt = upd_cnt + 1;
        if (frame_done) frame_cnt = frame_cnt + 1;
    end

    task automatic step(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic drive(input logic [5:0] s, input logic [7:0] g);
        bus.sel = s;
        bus.seg = g;
    endtask

    task automatic test_reset;
        sys_rst_n = 1'b0;
        drive(6'h00, 8'hFF);
        step(3);
        checks++; if (digits !== 24'h000000) begin failures++; $display("FAIL reset_digits: got %h expected %h", digits, 24'h000000); end
        checks++; if ({dp, digit_err} !== 12'h000) begin failures++; $display("FAIL reset_dp_err: got %h expected %h", {dp, digit_err}, 12'h000); end
        checks++; if ({upd, frame_done, data_valid} !== 3'b000) begin failures++; $display("FAIL reset_flags: got %b expected %b", {upd, frame_done, data_valid}, 3'b000); end
        sys_rst_n = 1'b1;
        step(2);
    endtask

    task automatic test_static;
        int u0, f0;
        u0 = upd_cnt;
        f0 = frame_cnt;
        drive(6'h3F, 8'hC0);
        step(16);
        checks++; if (upd !== 1'b0) begin failures++; $display("FAIL static_early: got %b expected %b", upd, 1'b0); end
        step(1);
        checks++; if ({upd, frame_done} !== 2'b11) begin failures++; $display("FAIL static_capture: got %b expected %b", {upd, frame_done}, 2'b11); end
        step(1);
        checks++; if (upd !== 1'b0) begin failures++; $display("FAIL static_pulse_width: got %b expected %b", upd, 1'b0); end
        step(40);
        checks++; if ((upd_cnt - u0) != 1) begin failures++; $display("FAIL static_upd_count: got %0d expected %0d", upd_cnt - u0, 1); end
        checks++; if ((frame_cnt - f0) != 1) begin failures++; $display("FAIL static_frame_count: got %0d expected %0d", frame_cnt - f0, 1); end
        checks++; if ({digits, dp, data_valid} !== {24'h000000, 6'h00, 1'b1}) begin failures++; $display("FAIL static_state: got %h expected %h", {digits, dp, data_valid}, {24'h000000, 6'h00, 1'b1}); end
    endtask

    task automatic test_scan;
        logic [7:0] pat [6];
        int u0, f0;
        pat[0] = 8'hF9; pat[1] = 8'hA4; pat[2] = 8'hB0;
        pat[3] = 8'h99; pat[4] = 8'h92; pat[5] = 8'h82;
        u0 = upd_cnt;
        for (int i = 0; i < 6; i++) begin
            f0 = frame_cnt;
            drive(6'b000001 << i, pat[i]);
            step(20);
            checks++;
            if ((frame_cnt - f0) != ((i == 5) ? 1 : 0)) begin
                failures++;
                $display("FAIL scan_frame_%0d: got %0d expected %0d", i, frame_cnt - f0, (i == 5) ? 1 : 0);
            end
        end
        checks++; if ((upd_cnt - u0) != 6) begin failures++; $display("FAIL scan_upd_count: got %0d expected %0d", upd_cnt - u0, 6); end
        checks++; if ({digits, dp} !== {24'h654321, 6'h00}) begin failures++; $display("FAIL scan_digits: got %h expected %h", {digits, dp}, {24'h654321, 6'h00}); end
    endtask

    task automatic test_glitch;
        int u0;
        u0 = upd_cnt;
        drive(6'h01, 8'h8E);
        step(20);
        drive(6'h01, 8'h88);
        step(10);
        checks++; if (digits !== 24'h65432F) begin failures++; $display("FAIL glitch_no_capture: got %h expected %h", digits, 24'h65432F); end
        drive(6'h01, 8'h8E);
        step(20);
        checks++; if ((upd_cnt - u0) != 2) begin failures++; $display("FAIL glitch_upd_count: got %0d expected %0d", upd_cnt - u0, 2); end
        checks++; if (digits !== 24'h65432F) begin failures++; $display("FAIL glitch_digits: got %h expected %h", digits, 24'h65432F); end
    endtask

    task automatic test_unrecognised(output logic [35:0] exp_state);
        int u0;
        u0 = upd_cnt;
        drive(6'h04, 8'h7F);
        step(20);
`ifdef SEG_DECODE_ERR_EN
        exp_state = {24'h654F2F, 6'h04, 6'h04};
        checks++; if ((upd_cnt - u0) != 1) begin failures++; $display("FAIL unrec_upd_count: got %0d expected %0d", upd_cnt - u0, 1); end
`else
        exp_state = {24'h65432F, 6'h00, 6'h00};
        checks++; if ((upd_cnt - u0) != 0) begin failures++; $display("FAIL unrec_upd_count: got %0d expected %0d", upd_cnt - u0, 0); end
`endif
        checks++; if ({digits, dp, digit_err} !== exp_state) begin failures++; $display("FAIL unrec_state: got %h expected %h", {digits, dp, digit_err}, exp_state); end
    endtask

    task automatic test_sel_zero(input logic [35:0] exp_state);
        int u0;
        u0 = upd_cnt;
        drive(6'h00, 8'hC0);
        step(40);
        checks++; if ((upd_cnt - u0) != 0) begin failures++; $display("FAIL selzero_upd_count: got %0d expected %0d", upd_cnt - u0, 0); end
        checks++; if ({digits, dp, digit_err, data_valid} !== {exp_state, 1'b1}) begin failures++; $display("FAIL selzero_state: got %h expected %h", {digits, dp, digit_err, data_valid}, {exp_state, 1'b1}); end
    endtask

    task automatic test_reset_midcount;
        drive(6'h02, 8'hA4);
        step(11);
        sys_rst_n = 1'b0;
        step(3);
        checks++; if ({digits, dp, digit_err} !== 36'h0) begin failures++; $display("FAIL midrst_regs: got %h expected %h", {digits, dp, digit_err}, 36'h0); end
        checks++; if ({upd, frame_done, data_valid} !== 3'b000) begin failures++; $display("FAIL midrst_flags: got %b expected %b", {upd, frame_done, data_valid}, 3'b000); end
        sys_rst_n = 1'b1;
        step(16);
        checks++; if (upd !== 1'b0) begin failures++; $display("FAIL midrst_early: got %b expected %b", upd, 1'b0); end
        step(1);
        checks++; if ({upd, frame_done, data_valid} !== 3'b100) begin failures++; $display("FAIL midrst_capture: got %b expected %b", {upd, frame_done, data_valid}, 3'b100); end
        checks++; if (digits !== 24'h000020) begin failures++; $display("FAIL midrst_digits: got %h expected %h", digits, 24'h000020); end
    endtask

    task automatic test_back_to_back;
        // Mask holds 02h; 3Dh completes it, then a new digit must not finish a frame.
        drive(6'h3D, 8'hC0);
        step(17);
        checks++; if ({upd, frame_done, data_valid} !== 3'b111) begin failures++; $display("FAIL b2b_complete: got %b expected %b", {upd, frame_done, data_valid}, 3'b111); end
        drive(6'h01, 8'hF9);
        step(17);
        checks++; if ({upd, frame_done} !== 2'b10) begin failures++; $display("FAIL b2b_no_carry: got %b expected %b", {upd, frame_done}, 2'b10); end
        checks++; if (digits !== 24'h000021) begin failures++; $display("FAIL b2b_digits: got %h expected %h", digits, 24'h000021); end
    endtask

    initial begin
        logic [35:0] exp_state;
        checks    = 0;
        failures  = 0;
        sys_rst_n = 1'b0;
        drive(6'h00, 8'hFF);
        test_reset();
        test_static();
        test_scan();
        test_glitch();
        test_unrecognised(exp_state);
        test_sel_zero(exp_state);
        test_reset_midcount();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
